fpu_dispatch: RTL and testbench

- Parametrised issue/collect front end for the floating-point units: N_UNITS unit slots, AXI-style valid/ready on the core side, and fixed-latency non-backpressured units on the unit side.
- Supersedes the single-outstanding operator mux.
- Multiple operations may be in flight across any mix of units; results return to the core strictly in issue order, with a tag.
- Sits between the execute stage and the fadd/fsub/fmul/fdiv/fneg/fcmp instances.

---
 rtl/fpu_pkg.sv | 23 ++
 rtl/fpu_sync_fifo.sv | 48 ++++
 rtl/fpu_dispatch.sv | 163 ++++++++++++++++
 tb/tb_fpu_dispatch.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared types and default widths for the floating-point dispatch front end.
package fpu_pkg;

    localparam int unsigned W     = 32;
    localparam int unsigned TAG_W = 5;
    localparam int unsigned OP_W  = 3;

    // Unit slot assignment; the op code presented by the core is the slot index.
    typedef enum logic [OP_W-1:0] {
        NEG = 3'd0,
        ADD = 3'd1,
        SUB = 3'd2,
        MUL = 3'd3,
        DIV = 3'd4,
        CMP = 3'd5
    } inst_type;

    typedef struct packed {
        logic [OP_W-1:0]  op;
        logic [TAG_W-1:0] tag;
    } order_entry_t;

endpackage

// File: rtl/fpu_sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers; head data is read directly from storage.
module fpu_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    push,
    input  logic [WIDTH-1:0]        push_data,
    input  logic                    pop,
    output logic [WIDTH-1:0]        pop_data,
    output logic                    empty,
    output logic                    full,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wptr;
    logic [PW-1:0]    rptr;

    // Storage is cleared on reset so an idle head reads as zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push && !full) begin
                mem[wptr[AW-1:0]] <= push_data;
                wptr              <= wptr + PW'(1);
            end
            if (pop && !empty) begin
                rptr <= rptr + PW'(1);
            end
        end
    end

    assign pop_data = mem[rptr[AW-1:0]];
    assign count    = wptr - rptr;
    assign empty    = (wptr == rptr);
    assign full     = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);

endmodule

// File: rtl/fpu_dispatch.sv
// Issue/collect front end for the FP units: multiple ops in flight, results
// returned to the core in issue order with the caller's tag.
module fpu_dispatch #(
    parameter int unsigned W       = 32,
    parameter int unsigned N_UNITS = 6,
    parameter int unsigned OP_W    = 3,
    parameter int unsigned TAG_W   = 5,
    parameter int unsigned DEPTH   = 8
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [OP_W-1:0]        in_op,
    input  logic [W-1:0]           in_a,
    input  logic [W-1:0]           in_b,
    input  logic [TAG_W-1:0]       in_tag,
    output logic [N_UNITS-1:0]     unit_valid,
    output logic [W-1:0]           unit_a,
    output logic [W-1:0]           unit_b,
    input  logic [N_UNITS-1:0]     unit_res_valid,
    input  logic [N_UNITS*W-1:0]   unit_res,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [W-1:0]           out_data,
    output logic [TAG_W-1:0]       out_tag,
    output logic [1:0]             err
);

    import fpu_pkg::*;

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    order_entry_t        oq_push_data;
    order_entry_t        oq_head;
    logic                oq_empty;
    logic                oq_full;
    logic [CW-1:0]       oq_count;
    logic [CW-1:0]       oq_count_next;

    logic                accept;
    logic                good_op;
    logic                issue;
    logic                retire;

    logic [N_UNITS-1:0]  head_hit;
    logic [N_UNITS-1:0]  cnt_nz;
    logic [N_UNITS-1:0]  capture;
    logic [N_UNITS-1:0]  rf_pop;
    logic [N_UNITS-1:0]  rf_empty;
    logic [W-1:0]        rf_head [N_UNITS];

    logic                unused_oq_status;

    assign accept  = in_valid && in_ready;
    assign good_op = 32'(in_op) < N_UNITS;
    assign issue   = accept && good_op;

    assign oq_push_data.op  = in_op;
    assign oq_push_data.tag = in_tag;

    // Outstanding count is the order-queue occupancy: one entry per issued op until it retires.
    fpu_sync_fifo #(
        .WIDTH ($bits(order_entry_t)),
        .DEPTH (DEPTH)
    ) u_order_q (
        .clk       (CLK),
        .rst_n     (RESET),
        .push      (issue),
        .push_data (oq_push_data),
        .pop       (retire),
        .pop_data  (oq_head),
        .empty     (oq_empty),
        .full      (oq_full),
        .count     (oq_count)
    );

    assign unused_oq_status = oq_full;

    // Per-unit outstanding counter and result FIFO; results with no matching issue are dropped.
    for (genvar g = 0; g < N_UNITS; g++) begin : g_unit
        logic           inc;
        logic [CW-1:0]  cnt;
        logic           rf_full;
        logic [CW-1:0]  rf_count;
        logic           unused_status;

        assign inc        = issue && (in_op == OP_W'(g));
        assign cnt_nz[g]  = (cnt != '0);
        assign capture[g] = unit_res_valid[g] && cnt_nz[g];
        assign rf_pop[g]  = retire && head_hit[g];

        always_ff @(posedge CLK or negedge RESET) begin
            if (!RESET) begin
                cnt <= '0;
            end else if (inc && !capture[g]) begin
                cnt <= cnt + CW'(1);
            end else if (!inc && capture[g]) begin
                cnt <= cnt - CW'(1);
            end
        end

        fpu_sync_fifo #(
            .WIDTH (W),
            .DEPTH (DEPTH)
        ) u_res_q (
            .clk       (CLK),
            .rst_n     (RESET),
            .push      (capture[g]),
            .push_data (unit_res[g*W +: W]),
            .pop       (rf_pop[g]),
            .pop_data  (rf_head[g]),
            .empty     (rf_empty[g]),
            .full      (rf_full),
            .count     (rf_count)
        );

        assign unused_status = ^{rf_full, rf_count};
    end

    // Head of the order queue selects which result FIFO feeds the output.
    always_comb begin
        head_hit = '0;
        out_data = '0;
        for (int unsigned i = 0; i < N_UNITS; i++) begin
            head_hit[i] = (32'(oq_head.op) == i);
            if (head_hit[i]) begin
                out_data = out_data | rf_head[i];
            end
        end
    end

    assign out_valid = !oq_empty && |(head_hit & ~rf_empty);
    assign out_tag   = oq_head.tag;
    assign retire    = out_valid && out_ready;

    assign oq_count_next = oq_count + CW'(issue) - CW'(retire);

    // Issue strobe, shared operands, ready and sticky error flags.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            in_ready   <= 1'b1;
            unit_valid <= '0;
            unit_a     <= '0;
            unit_b     <= '0;
            err        <= '0;
        end else begin
            in_ready   <= oq_count_next < CW'(DEPTH);
            unit_valid <= issue ? (N_UNITS'(1) << in_op) : '0;
            if (issue) begin
                unit_a <= in_a;
                unit_b <= in_b;
            end
            if (accept && !good_op) begin
                err[0] <= 1'b1;
            end
            if (|(unit_res_valid & ~cnt_nz)) begin
                err[1] <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fpu_dispatch.sv
// Directed bench for fpu_dispatch with a fixed-latency unit model per slot.
module tb_fpu_dispatch;

    import fpu_pkg::*;

    localparam int unsigned NU = 6;

    logic              CLK = 1'b0;
    logic              RESET = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [2:0]        in_op = '0;
    logic [31:0]       in_a = '0;
    logic [31:0]       in_b = '0;
    logic [4:0]        in_tag = '0;
    logic [NU-1:0]     unit_valid;
    logic [31:0]       unit_a;
    logic [31:0]       unit_b;
    logic [NU-1:0]     unit_res_valid = '0;
    logic [NU*32-1:0]  unit_res = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [31:0]       out_data;
    logic [4:0]        out_tag;
    logic [1:0]        err;

    int                compared = 0;
    int                mismatched = 0;
    int                cyc = 0;
    int                lat [NU];
    int                due [NU][16];
    logic [31:0]       val [NU][16];
    int                wr [NU];
    int                rd [NU];
    logic [NU-1:0]     spur_mask = '0;

    fpu_dispatch dut (
        .CLK            (CLK),
        .RESET          (RESET),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_op          (in_op),
        .in_a           (in_a),
        .in_b           (in_b),
        .in_tag         (in_tag),
        .unit_valid     (unit_valid),
        .unit_a         (unit_a),
        .unit_b         (unit_b),
        .unit_res_valid (unit_res_valid),
        .unit_res       (unit_res),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .out_tag        (out_tag),
        .err            (err)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] unit_result(input int u, input logic [31:0] a, input logic [31:0] b);
        if (u == int'(ADD) && a == 32'h3F80_0000 && b == 32'h4000_0000) return 32'h4040_0000;
        return a + b;
    endfunction

    // Unit model: records strobes and drives each result lat[u] cycles later, held for one cycle.
    always @(negedge CLK) begin
        cyc++;
        unit_res_valid = spur_mask;
        for (int i = 0; i < NU; i++) begin
            if (spur_mask[i]) unit_res[i*32 +: 32] = 32'hDEAD_BEEF;
        end
        for (int i = 0; i < NU; i++) begin
            if (unit_valid[i]) begin
                due[i][wr[i]] = cyc + lat[i];
                val[i][wr[i]] = unit_result(i, unit_a, unit_b);
                wr[i] = (wr[i] + 1) % 16;
            end
            if (rd[i] != wr[i] && due[i][rd[i]] == cyc) begin
                unit_res_valid[i]    = 1'b1;
                unit_res[i*32 +: 32] = val[i][rd[i]];
                rd[i] = (rd[i] + 1) % 16;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", nm, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] tag);
        logic ok;
        int   n;
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        in_tag   = tag;
        n = 0;
        do begin
            ok = in_ready;
            step();
            n++;
        end while (!ok && n < 50);
        in_valid = 1'b0;
        chk("issue accepted", 32'(ok), 32'd1);
    endtask

    task automatic wait_out(input string nm);
        int n;
        n = 0;
        while (!out_valid && n < 40) begin
            step();
            n++;
        end
        chk(nm, 32'(out_valid), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int seen;
        for (int i = 0; i < NU; i++) begin
            lat[i] = 1;
            wr[i]  = 0;
            rd[i]  = 0;
        end

        // Reset state
        repeat (3) @(posedge CLK);
        #1;
        RESET = 1'b1;
        step();
        chk("rst in_ready",   32'(in_ready),   32'd1);
        chk("rst unit_valid", 32'(unit_valid), 32'd0);
        chk("rst unit_a",     unit_a,          32'd0);
        chk("rst unit_b",     unit_b,          32'd0);
        chk("rst out_valid",  32'(out_valid),  32'd0);
        chk("rst out_data",   out_data,        32'd0);
        chk("rst out_tag",    32'(out_tag),    32'd0);
        chk("rst err",        32'(err),        32'd0);

        // Single ADD through a 4-cycle unit
        lat[int'(ADD)] = 4;
        out_ready = 1'b1;
        issue(ADD, 32'h3F80_0000, 32'h4000_0000, 5'd3);
        chk("t1 strobe",  32'(unit_valid), 32'h02);
        chk("t1 unit_a",  unit_a,          32'h3F80_0000);
        chk("t1 unit_b",  unit_b,          32'h4000_0000);
        step();
        chk("t1 strobe one cycle", 32'(unit_valid), 32'd0);
        wait_out("t1 out_valid");
        chk("t1 out_data", out_data,      32'h4040_0000);
        chk("t1 out_tag",  32'(out_tag),  32'd3);
        chk("t1 err",      32'(err),      32'd0);
        step();
        chk("t1 drained",  32'(out_valid), 32'd0);

        // Slow DIV then fast NEG: NEG result must wait behind DIV
        lat[int'(DIV)] = 12;
        lat[int'(NEG)] = 1;
        issue(DIV, 32'h100, 32'h11, 5'd1);
        issue(NEG, 32'h200, 32'h22, 5'd2);
        repeat (3) step();
        chk("t2 neg held", 32'(out_valid), 32'd0);
        wait_out("t2 first valid");
        chk("t2 first tag",  32'(out_tag), 32'd1);
        chk("t2 first data", out_data,     32'h111);
        step();
        wait_out("t2 second valid");
        chk("t2 second tag",  32'(out_tag), 32'd2);
        chk("t2 second data", out_data,     32'h222);
        step();

        // Fill to DEPTH with the consumer stalled, then drain
        lat[int'(MUL)] = 2;
        out_ready = 1'b0;
        for (int t = 0; t < 8; t++) begin
            in_valid = 1'b1;
            in_op    = MUL;
            in_a     = 32'(t);
            in_b     = 32'h300;
            in_tag   = 5'(t);
            chk("t3 ready while filling", 32'(in_ready), 32'd1);
            step();
        end
        in_a   = 32'd8;
        in_tag = 5'd8;
        chk("t3 full not ready", 32'(in_ready), 32'd0);
        repeat (5) step();
        chk("t3 still not ready", 32'(in_ready),  32'd0);
        chk("t3 head valid",      32'(out_valid), 32'd1);
        chk("t3 head tag",        32'(out_tag),   32'd0);
        step();
        chk("t3 stable tag",  32'(out_tag), 32'd0);
        chk("t3 stable data", out_data,     32'h300);
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            chk("t3 drain valid", 32'(out_valid), 32'd1);
            chk("t3 drain tag",   32'(out_tag),   32'(k));
            chk("t3 drain data",  out_data,       32'h300 + 32'(k));
            if (k == 1) chk("t3 ready after first retire", 32'(in_ready), 32'd1);
            step();
            if (k == 1) begin
                in_valid = 1'b0;
                chk("t3 ready after accept+retire", 32'(in_ready), 32'd1);
            end
        end
        wait_out("t3 ninth valid");
        chk("t3 ninth tag",  32'(out_tag), 32'd8);
        chk("t3 ninth data", out_data,     32'h308);
        step();

        // Seven outstanding, accept and retire in the same cycle
        out_ready = 1'b0;
        for (int t = 0; t < 7; t++) begin
            issue(MUL, 32'h10 + 32'(t), 32'h400, 5'(10 + t));
        end
        repeat (4) step();
        chk("t4 ready at 7", 32'(in_ready), 32'd1);
        chk("t4 head tag",   32'(out_tag),  32'd10);
        in_valid  = 1'b1;
        in_op     = MUL;
        in_a      = 32'h17;
        in_b      = 32'h400;
        in_tag    = 5'd17;
        out_ready = 1'b1;
        step();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("t4 ready unchanged", 32'(in_ready), 32'd1);
        chk("t4 head advanced",   32'(out_tag),  32'd11);
        issue(MUL, 32'h18, 32'h400, 5'd18);
        chk("t4 full after one more", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        for (int t = 11; t <= 18; t++) begin
            wait_out("t4 drain valid");
            chk("t4 drain tag",  32'(out_tag), 32'(t));
            chk("t4 drain data", out_data,     32'h410 + 32'(t - 10));
            step();
        end

        // Bad op code and a spurious unit result
        issue(3'd7, 32'h1, 32'h2, 5'd9);
        chk("t5 no strobe", 32'(unit_valid), 32'd0);
        chk("t5 err bad op", 32'(err), 32'd1);
        repeat (3) step();
        chk("t5 no output", 32'(out_valid), 32'd0);
        chk("t5 ready",     32'(in_ready),  32'd1);
        spur_mask = 6'b000100;
        step();
        spur_mask = '0;
        chk("t5 err spurious", 32'(err), 32'd3);
        repeat (2) step();
        chk("t5 spurious dropped", 32'(out_valid), 32'd0);

        // Reset with three ops in flight
        issue(DIV, 32'h1, 32'h1, 5'd20);
        issue(DIV, 32'h2, 32'h2, 5'd21);
        issue(DIV, 32'h3, 32'h3, 5'd22);
        step();
        RESET = 1'b0;
        #1;
        chk("t6 async out_valid", 32'(out_valid), 32'd0);
        @(posedge CLK);
        #1;
        RESET = 1'b1;
        step();
        chk("t6 ready after reset", 32'(in_ready),  32'd1);
        chk("t6 out_valid low",     32'(out_valid), 32'd0);
        chk("t6 err cleared",       32'(err),       32'd0);
        seen = 0;
        repeat (20) begin
            step();
            if (out_valid) seen = 1;
        end
        chk("t6 no late output", 32'(seen), 32'd0);
        chk("t6 late results flagged", 32'(err), 32'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
